// File: rtl/rs232_rx.sv
// RS-232 receiver: 8 data bits LSB first, 1 stop bit, mid-bit sampling off a 2-flop synchronizer.
// Define RS232_RX_PARITY_EN to add one even-parity bit between the data and stop bits.
module rs232_rx #(
    parameter int CLK_REF   = 100,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk_ref,
    input  logic       rst,
    input  logic       i_rx_pin,
    output logic [7:0] o_rx_dat,
    output logic       o_rx_valid,
    output logic       o_rx_frame_err,
    output logic       o_rx_parity_err,
    output logic       o_rx_busy
);

    localparam int BIT_CNT  = CLK_REF * 1000000 / BAUD_RATE;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CW       = $clog2(BIT_CNT);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef RS232_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      sync_q;
    logic            prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      dat_q, dat_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            rx;
    logic            fall;
    logic            at_bit;
    logic            par_bad;

`ifdef RS232_RX_PARITY_EN
    logic            par_bad_q, par_bad_d;
    logic            perr_q, perr_d;
    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    assign rx     = sync_q[1];
    assign fall   = prev_q & ~rx;
    assign at_bit = (cnt_q == CW'(BIT_CNT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = at_bit ? '0 : cnt_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        dat_d    = dat_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
`ifdef RS232_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                bit_d = '0;
                if (fall) state_d = StStart;
            end
            StStart: begin
                // Mid start bit: a line back high means the edge was a glitch.
                if (cnt_q == CW'(HALF_CNT - 1)) begin
                    cnt_d   = '0;
                    state_d = rx ? StIdle : StData;
                end
            end
            StData: begin
                if (at_bit) begin
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef RS232_RX_PARITY_EN
            StParity: begin
                if (at_bit) begin
                    par_bad_d = rx ^ (^shift_q);
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (at_bit) begin
                    state_d = StIdle;
                    ferr_d  = ~rx;
`ifdef RS232_RX_PARITY_EN
                    perr_d  = par_bad;
`endif
                    if (rx && !par_bad) begin
                        dat_d   = shift_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dat_q   <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], i_rx_pin};
            prev_q  <= rx;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dat_q   <= dat_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef RS232_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign o_rx_dat       = dat_q;
    assign o_rx_valid     = valid_q;
    assign o_rx_frame_err = ferr_q;
    assign o_rx_busy      = (state_q != StIdle);
`ifdef RS232_RX_PARITY_EN
    assign o_rx_parity_err = perr_q;
`else
    assign o_rx_parity_err = 1'b0;
`endif

endmodule
